// File: rtl/synch_pkg.sv
// Shared types and constants for the synchronous counter library (up counter and down timer).
package synch_pkg;

  localparam int SYNCH_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

endpackage

// File: rtl/synch_prescaler.sv
// Tick generator for the down timer: one tick every PRESCALE enabled cycles.
module synch_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] cnt;

  // tick marks the enabled cycle on which the counter wraps back to 0
  assign tick = en && (cnt == PW'(PRESCALE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + PW'(1);
    end
  end

endmodule

// File: rtl/synch_down_timer.sv
// Programmable down counter/timer with load handshake, one-shot or auto-reload, terminal-count pulse.
// Optional build macro SYNCH_DOWN_PRESCALE_EN: count steps only every PRESCALE enabled cycles.
//
// state   | meaning
// IDLE    | after reset or stop, waiting for a load
// RUN     | counting down toward terminal count
// EXPIRED | one-shot finished (or zero loaded), outBus holds 0
module synch_down_timer
  import synch_pkg::*;
#(
  parameter int WIDTH    = SYNCH_WIDTH,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             stop,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_auto,
  output logic             load_ready,
  output logic [WIDTH-1:0] outBus,
  output logic             tc,
  output logic             busy
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count, count_nxt;
  logic [WIDTH-1:0] reload, reload_nxt;
  logic             auto_q, auto_nxt;
  logic             tc_q, tc_nxt;
  logic             load_acc;
  logic             run_en;
  logic             tick;
  logic             step;

  assign load_acc = load_valid && load_ready;
  assign run_en   = (state == RUN) && en;

`ifdef SYNCH_DOWN_PRESCALE_EN
  synch_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (load_acc || stop),
    .en   (run_en),
    .tick (tick)
  );
`else
  // Without the prescaler every enabled RUN cycle is a step; any legal PRESCALE (>=1) yields 1.
  assign tick = (PRESCALE > 0);
`endif

  assign step = run_en && tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (stop) begin
      state_nxt = IDLE;
    end else if (load_acc) begin
      state_nxt = (load_data != '0) ? RUN : EXPIRED;
    end else if (step && (count == WIDTH'(1)) && !auto_q) begin
      state_nxt = EXPIRED;
    end
  end

  always_comb begin
    busy       = (state == RUN);
    load_ready = (state != RUN) && !stop;
  end

  always_comb begin
    count_nxt  = count;
    reload_nxt = reload;
    auto_nxt   = auto_q;
    tc_nxt     = 1'b0;
    if (stop) begin
      count_nxt = '0;
    end else if (load_acc) begin
      count_nxt = load_data;
      if (load_data != '0) begin
        reload_nxt = load_data;
        auto_nxt   = load_auto;
      end else begin
        tc_nxt = 1'b1;
      end
    end else if (step) begin
      if (count > WIDTH'(1)) begin
        count_nxt = count - WIDTH'(1);
      end else begin
        // terminal step: reload for periodic mode, park at zero for one-shot
        tc_nxt    = 1'b1;
        count_nxt = auto_q ? reload : '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      reload <= '0;
      auto_q <= 1'b0;
      tc_q   <= 1'b0;
    end else begin
      count  <= count_nxt;
      reload <= reload_nxt;
      auto_q <= auto_nxt;
      tc_q   <= tc_nxt;
    end
  end

  assign outBus = count;
  assign tc     = tc_q;

endmodule

// File: tb/tb_synch_down_timer.sv
// Self-checking bench for synch_down_timer: directed steps then random traffic against a behavioural model.
module tb_synch_down_timer;

  localparam int WIDTH    = 4;
  localparam int PRESCALE = 4;
`ifdef SYNCH_DOWN_PRESCALE_EN
  localparam int PS = PRESCALE;
`else
  localparam int PS = 1;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             stop = 1'b0;
  logic             load_valid = 1'b0;
  logic [WIDTH-1:0] load_data = '0;
  logic             load_auto = 1'b0;
  logic             load_ready;
  logic [WIDTH-1:0] outBus;
  logic             tc;
  logic             busy;

  int errors = 0;
  int checks = 0;

  // behavioural model: running flag, current value, reload value, mode, prescale phase
  bit m_active;
  bit m_auto;
  bit m_tc;
  int m_val;
  int m_reload;
  int m_phase;
  int tc_seen;

  synch_down_timer #(
    .WIDTH   (WIDTH),
    .PRESCALE(PRESCALE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .stop       (stop),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_auto  (load_auto),
    .load_ready (load_ready),
    .outBus     (outBus),
    .tc         (tc),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_auto = 0; m_tc = 0;
    m_val = 0; m_reload = 0; m_phase = 0;
  endtask

  task automatic model_step(input bit s, input bit lv, input int ld, input bit la, input bit e);
    m_tc = 0;
    if (s) begin
      m_active = 0; m_val = 0; m_phase = 0;
    end else if (!m_active && lv) begin
      m_phase = 0;
      m_val   = ld;
      if (ld == 0) begin
        m_tc = 1;
      end else begin
        m_active = 1; m_reload = ld; m_auto = la;
      end
    end else if (m_active && e) begin
      m_phase++;
      if (m_phase == PS) begin
        m_phase = 0;
        if (m_val > 1) begin
          m_val--;
        end else begin
          m_tc = 1;
          if (m_auto) m_val = m_reload;
          else begin m_val = 0; m_active = 0; end
        end
      end
    end
  endtask

  task automatic cyc(input bit s, input bit lv, input int ld, input bit la, input bit e);
    stop = s; load_valid = lv; load_data = WIDTH'(ld); load_auto = la; en = e;
    #1;
    chk("load_ready", load_ready, 32'(!m_active && !s));
    model_step(s, lv, ld, la, e);
    @(posedge clk);
    #1;
    chk("outBus", outBus, 32'(m_val));
    chk("tc", tc, 32'(m_tc));
    chk("busy", busy, 32'(m_active));
    if (tc) tc_seen++;
  endtask

  initial begin
    int n;
    model_reset();
    #2;
    chk("reset_outBus", outBus, 0);
    chk("reset_tc", tc, 0);
    chk("reset_busy", busy, 0);
    #5 rst = 1'b0;
    #0;
    chk("reset_ready", load_ready, 1);

    // load 4 one-shot, count down to 0 with a single tc
    tc_seen = 0;
    cyc(0, 1, 4, 0, 1);
    for (int i = 0; i < 4 * PS + 1; i++) cyc(0, 0, 0, 0, 1);
    chk("oneshot_tc_count", tc_seen, 1);
    chk("oneshot_final", outBus, 0);

    // load 3 auto-reload, 9 enabled cycles
    tc_seen = 0;
    cyc(0, 1, 3, 1, 1);
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 1);
    chk("auto_tc_count", tc_seen, (9 / PS) / 3);
    chk("auto_busy", busy, 1);
    cyc(1, 0, 0, 0, 1);

    // load 2 with en gaps
    cyc(0, 1, 2, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 2 * PS + 1; i++) cyc(0, 0, 0, 0, 1);

    // load 0 then load 15, no wrap
    cyc(0, 1, 0, 0, 1);
    chk("zero_tc", tc, 1);
    cyc(0, 0, 0, 0, 1);
    tc_seen = 0;
    cyc(0, 1, 15, 0, 1);
    for (int i = 0; i < 15 * PS + 3; i++) cyc(0, 0, 0, 0, 1);
    chk("max_tc_count", tc_seen, 1);
    chk("max_nowrap", outBus, 0);

    // stop at outBus=2 with a simultaneous load offer
    cyc(0, 1, 5, 1, 1);
    for (int i = 0; i < 100 && m_val != 2; i++) cyc(0, 0, 0, 0, 1);
    chk("reach2", outBus, 2);
    cyc(1, 1, 7, 0, 1);
    chk("stop_outBus", outBus, 0);
    chk("stop_busy", busy, 0);

    // terminal-count latency for load 2
    cyc(0, 1, 2, 0, 1);
    n = 0;
    while (!tc && n < 100) begin
      cyc(0, 0, 0, 0, 1);
      n++;
    end
    chk("tc_latency", n, 2 * PS);

    // async reset mid-run at outBus=5
    cyc(0, 1, 9, 1, 1);
    for (int i = 0; i < 200 && m_val != 5; i++) cyc(0, 0, 0, 0, 1);
    chk("reach5", outBus, 5);
    #2 rst = 1'b1;
    #1;
    chk("midrst_outBus", outBus, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_tc", tc, 0);
    model_reset();
    #2 rst = 1'b0;
    #0;
    chk("midrst_ready", load_ready, 1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      bit s, lv, la, e;
      int ld;
      s  = ($urandom_range(0, 19) == 0);
      lv = ($urandom_range(0, 2) == 0);
      la = $urandom_range(0, 1);
      e  = ($urandom_range(0, 3) != 0);
      ld = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 4);
      cyc(s, lv, ld, la, e);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
